// File: rtl/mdr_ctrl_if.sv
// Signal bundle between the switch/button front end, the arithmetic core
// and the mdr_ctrl sequencer.
//
// Handshake semantics: there is no back-pressure on this bus. i_start,
// i_valid and i_done are single-cycle strobes; a strobe is consumed on the
// rising edge where it is high, provided the sequencer is in a state that
// accepts it, and is otherwise dropped. The sequencer's own o_core_start is
// a single-cycle strobe to the core. o_ready/o_wait_x/o_wait_y/o_busy/
// o_valid/o_error are level status flags that tell the producers which
// strobe is accepted next.
interface mdr_ctrl_if #(
    parameter int DW = 16
);
    logic              i_start;
    logic              i_valid;
    logic [DW-1:0]     i_data;
    logic [1:0]        i_op;
    logic              i_done;
    logic [2*DW-1:0]   i_result;
    logic [DW-1:0]     i_rem;

    logic [DW-1:0]     o_x;
    logic [DW-1:0]     o_y;
    logic [1:0]        o_op;
    logic              o_core_start;
    logic [2*DW-1:0]   o_result;
    logic [DW-1:0]     o_rem;
    logic              o_ready;
    logic              o_wait_x;
    logic              o_wait_y;
    logic              o_busy;
    logic              o_valid;
    logic              o_error;

    // Sequencer side
    modport slave (
        input  i_start, i_valid, i_data, i_op, i_done, i_result, i_rem,
        output o_x, o_y, o_op, o_core_start, o_result, o_rem,
        output o_ready, o_wait_x, o_wait_y, o_busy, o_valid, o_error
    );

    // Environment side (front end, core, testbench)
    modport master (
        output i_start, i_valid, i_data, i_op, i_done, i_result, i_rem,
        input  o_x, o_y, o_op, o_core_start, o_result, o_rem,
        input  o_ready, o_wait_x, o_wait_y, o_busy, o_valid, o_error
    );
endinterface

// File: rtl/mdr_ctrl.sv
// Operand-collection and sequencing controller for a multiply / divide /
// square-root core. Latches X (with opcode) and Y from the switch stage,
// fires the core, waits for its done with a bounded timeout and holds the
// result (or an error) until the next start request.
module mdr_ctrl #(
    parameter int DW  = 16,
    parameter int TMO = 1023
) (
    input  logic        clk,
    input  logic        rst,
    mdr_ctrl_if.slave   bus,
    output logic [2:0]  dbg_state_o
);
    localparam int              CW    = $clog2(TMO + 1);
    localparam logic [CW-1:0]   TMO_C = CW'(TMO);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_SQRT = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_X = 3'd1,
        WAIT_Y = 3'd2,
        START  = 3'd3,
        BUSY   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     x_q, x_d;
    logic [DW-1:0]     y_q, y_d;
    logic [1:0]        op_q, op_d;
    logic [2*DW-1:0]   result_q, result_d;
    logic [DW-1:0]     rem_q, rem_d;

    // State and datapath registers; reset aborts any operation at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            op_q     <= op_d;
            result_q <= result_d;
            rem_q    <= rem_d;
        end
    end

    // Next-state and datapath update; a start request from any waiting or
    // terminal state restarts the sequence with all operands/results zeroed
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        op_d     = op_q;
        result_d = result_q;
        rem_d    = rem_q;

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = WAIT_X;
                end
            end

            WAIT_X: begin
                if (bus.i_start) begin
                    state_d  = WAIT_X;
                    x_d      = '0;
                    y_d      = '0;
                    op_d     = '0;
                    result_d = '0;
                    rem_d    = '0;
                end else if (bus.i_valid) begin
                    x_d  = bus.i_data;
                    op_d = bus.i_op;
                    if (bus.i_op == OP_NONE) begin
                        state_d = ERR;
                    end else if (bus.i_op == OP_SQRT) begin
                        // sqrt is unary: skip Y and present a clean zero
                        y_d     = '0;
                        state_d = START;
                    end else begin
                        state_d = WAIT_Y;
                    end
                end
            end

            WAIT_Y: begin
                if (bus.i_start) begin
                    state_d  = WAIT_X;
                    x_d      = '0;
                    y_d      = '0;
                    op_d     = '0;
                    result_d = '0;
                    rem_d    = '0;
                end else if (bus.i_valid) begin
                    y_d = bus.i_data;
                    if (op_q == OP_DIV && bus.i_data == '0) begin
                        state_d = ERR;
                    end else begin
                        state_d = START;
                    end
                end
            end

            START: begin
                cnt_d   = '0;
                state_d = BUSY;
            end

            BUSY: begin
                // done beats the timeout even on the final counted cycle
                if (bus.i_done) begin
                    result_d = bus.i_result;
                    rem_d    = (op_q == OP_DIV) ? bus.i_rem : '0;
                    state_d  = DONE;
                end else if (cnt_q == TMO_C) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DONE, ERR: begin
                if (bus.i_start) begin
                    state_d  = WAIT_X;
                    x_d      = '0;
                    y_d      = '0;
                    op_d     = '0;
                    result_d = '0;
                    rem_d    = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore status decode and registered data outputs
    assign bus.o_ready      = (state_q == IDLE);
    assign bus.o_wait_x     = (state_q == WAIT_X);
    assign bus.o_wait_y     = (state_q == WAIT_Y);
    assign bus.o_busy       = (state_q == START) || (state_q == BUSY);
    assign bus.o_core_start = (state_q == START);
    assign bus.o_valid      = (state_q == DONE);
    assign bus.o_error      = (state_q == ERR);

    assign bus.o_x      = x_q;
    assign bus.o_y      = y_q;
    assign bus.o_op     = op_q;
    assign bus.o_result = result_q;
    assign bus.o_rem    = rem_q;

    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_mdr_ctrl.sv
// Self-checking bench for mdr_ctrl: drives the front-end strobes, models
// the arithmetic core, and scores the captured results.
module tb_mdr_ctrl;
    localparam int DW  = 16;
    localparam int TMO = 4;
    localparam int W   = 1 + 2*DW + DW;   // {error, result, rem}

    logic clk = 1'b0;
    logic rst;
    logic [2:0] dbg_state;

    int n_checks  = 0;
    int n_errors  = 0;
    int cs_count  = 0;
    int core_lat  = 0;   // 0: core never answers
    logic [W-1:0] exp_q[$];

    // Clock and DUT
    always #5 clk = ~clk;

    mdr_ctrl_if #(.DW(DW)) bus();

    mdr_ctrl #(.DW(DW), .TMO(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Count core start pulses on the falling edge
    always @(negedge clk) begin
        if (bus.o_core_start) cs_count <= cs_count + 1;
    end

    function automatic logic [15:0] isqrt(input logic [15:0] v);
        logic [31:0] r;
        r = 0;
        while ((r + 1) * (r + 1) <= {16'h0, v}) r = r + 1;
        return r[15:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic core model: answers core_lat cycles after the start pulse
    initial begin
        logic [31:0] r;
        logic [15:0] m;
        int lat;
        bus.i_done   = 1'b0;
        bus.i_result = '0;
        bus.i_rem    = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.o_core_start && core_lat > 0) begin
                lat = core_lat;
                repeat (lat) @(posedge clk);
                #1;
                r = '0;
                m = 16'hBEEF;
                case (bus.o_op)
                    2'b01: r = {16'h0, bus.o_x} * {16'h0, bus.o_y};
                    2'b10: if (bus.o_y != 0) begin
                        r = {16'h0, bus.o_x / bus.o_y};
                        m = bus.o_x % bus.o_y;
                    end
                    2'b11: r = {16'h0, isqrt(bus.o_x)};
                    default: r = 32'hA5A5_A5A5;
                endcase
                bus.i_done   = 1'b1;
                bus.i_result = r;
                bus.i_rem    = m;
                @(posedge clk); #1;
                bus.i_done   = 1'b0;
            end
        end
    end

    // Driver tasks: entered and left at posedge + 1
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        step(1);
        bus.i_start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] op);
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_op    = op;
        step(1);
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        logic [W-1:0] e;
        int k;
        k = 0;
        while (!(bus.o_valid || bus.o_error) && k < 50) begin
            step(1);
            k++;
        end
        if (!(bus.o_valid || bus.o_error)) begin
            check({tag, "_timeout"}, 0, 1);
        end else if (exp_q.size() == 0) begin
            check({tag, "_no_exp"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_out"}, {bus.o_valid, bus.o_error, bus.o_result, bus.o_rem},
                  {~e[W-1], e});
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic [1:0] op, input int lat, input bit late);
        logic [31:0] r;
        logic [15:0] m;
        int cs0;
        core_lat = lat;
        cs0 = cs_count;
        r = '0;
        m = '0;
        case (op)
            2'b01: r = {16'h0, x} * {16'h0, y};
            2'b10: begin
                r = {16'h0, x / y};
                m = x % y;
            end
            default: r = {16'h0, isqrt(x)};
        endcase
        if (late) exp_q.push_back({1'b1, 32'h0, 16'h0});
        else      exp_q.push_back({1'b0, r, m});
        pulse_start();
        send(x, op);
        if (op != 2'b11) send(y, 2'b00);
        wait_end(tag);
        check({tag, "_cs"}, cs_count - cs0, 1);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        int cs0;
        logic [1:0] op;
        logic [15:0] x, y;
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_op    = '0;
        rst = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.o_ready, 1);
        check("rst_status", {bus.o_wait_x, bus.o_wait_y, bus.o_busy, bus.o_valid,
                             bus.o_error, bus.o_core_start}, 0);
        check("rst_opnd", {bus.o_x, bus.o_y, bus.o_op}, 0);
        check("rst_res", {bus.o_result, bus.o_rem}, 0);
        rst = 1'b1;
        step(1);

        // IDLE ignores i_valid
        send(16'h1234, 2'b01);
        check("idle_ign", {bus.o_ready, bus.o_x}, {1'b1, 16'h0});

        // Multiply 0x12 * 3
        core_lat = 1;
        cs0 = cs_count;
        pulse_start();
        check("mul_wx", bus.o_wait_x, 1);
        send(16'h0012, 2'b01);
        check("mul_wy", bus.o_wait_y, 1);
        exp_q.push_back({1'b0, 32'h36, 16'h0});
        send(16'h0003, 2'b00);
        wait_end("mul");
        check("mul_opnd", {bus.o_x, bus.o_y}, {16'h12, 16'h3});
        check("mul_cs", cs_count - cs0, 1);

        // Divide by zero
        cs0 = cs_count;
        pulse_start();
        send(16'h0064, 2'b10);
        exp_q.push_back({1'b1, 32'h0, 16'h0});
        send(16'h0000, 2'b00);
        wait_end("dz");
        check("dz_cs", cs_count - cs0, 0);
        check("dz_opnd", {bus.o_x, bus.o_y, bus.o_op}, {16'h64, 16'h0, 2'b10});
        step(3);
        check("dz_hold", bus.o_error, 1);
        pulse_start();
        check("dz_restart", {bus.o_wait_x, bus.o_error}, 2'b10);
        check("dz_clear", {bus.o_x, bus.o_y, bus.o_op, bus.o_result, bus.o_rem}, 0);

        // Normal divide from WAIT_X (restart leaves us there)
        run_op("div", 16'd100, 16'd7, 2'b10, 2, 1'b0);

        // Square root 0x51
        core_lat = 2;
        cs0 = cs_count;
        pulse_start();
        exp_q.push_back({1'b0, 32'd9, 16'h0});
        send(16'h0051, 2'b11);
        check("sq_start", {bus.o_wait_y, bus.o_busy, bus.o_core_start}, 3'b011);
        check("sq_y", bus.o_y, 0);
        wait_end("sq");
        check("sq_cs", cs_count - cs0, 1);

        // Timeout: no done, error five edges after BUSY entry
        core_lat = 0;
        pulse_start();
        send(16'd5, 2'b01);
        send(16'd6, 2'b00);
        check("to_start", bus.o_core_start, 1);
        step(1);
        check("to_busy", bus.o_busy, 1);
        step(4);
        check("to_pre", {bus.o_busy, bus.o_error}, 2'b10);
        step(1);
        check("to_err", {bus.o_busy, bus.o_error}, 2'b01);
        exp_q.push_back({1'b1, 32'h0, 16'h0});
        wait_end("to");

        // done on the last counted cycle wins; one cycle later is too late
        run_op("to_edge", 16'd5, 16'd6, 2'b01, 5, 1'b0);
        run_op("to_late", 16'd5, 16'd6, 2'b01, 6, 1'b1);

        // Opcode none
        pulse_start();
        exp_q.push_back({1'b1, 32'h0, 16'h0});
        send(16'h2222, 2'b00);
        wait_end("op0");

        // start beats valid in WAIT_Y and WAIT_X
        pulse_start();
        send(16'h0010, 2'b01);
        check("sv_wy", bus.o_wait_y, 1);
        bus.i_start = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 16'h0055;
        bus.i_op    = 2'b01;
        step(1);
        check("sv_y_state", {bus.o_wait_x, bus.o_wait_y}, 2'b10);
        check("sv_y_clear", {bus.o_x, bus.o_y, bus.o_op}, 0);
        bus.i_data  = 16'h0077;
        step(1);
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        check("sv_x", {bus.o_wait_x, bus.o_x, bus.o_op}, {1'b1, 16'h0, 2'b00});

        // Random mul/div/sqrt traffic
        for (int i = 0; i < 16; i++) begin
            op = 2'($urandom_range(1, 3));
            x  = 16'($urandom_range(0, 16'hFFFF));
            y  = 16'($urandom_range((op == 2'b10) ? 1 : 0, 16'hFFFF));
            run_op("rnd", x, y, op, $urandom_range(1, 3), 1'b0);
        end

        // Reset in BUSY; the core's late done must be ignored in IDLE
        core_lat = 3;
        cs0 = cs_count;
        pulse_start();
        send(16'd7, 2'b01);
        send(16'd9, 2'b00);
        step(1);
        check("rb_busy", bus.o_busy, 1);
        rst = 1'b0;
        #1;
        check("rb_ready", bus.o_ready, 1);
        check("rb_status", {bus.o_wait_x, bus.o_wait_y, bus.o_busy, bus.o_valid,
                            bus.o_error, bus.o_core_start}, 0);
        check("rb_data", {bus.o_x, bus.o_y, bus.o_op, bus.o_result, bus.o_rem}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        step(5);
        check("rb_idle", {bus.o_ready, bus.o_valid, bus.o_error, bus.o_result}, {3'b100, 32'h0});
        check("rb_cs", cs_count - cs0, 1);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mdr_ctrl.md
MDR_CTRL -- requirements
Module: mdr_ctrl

Interface
REQ-001 Parameter DW, default 16: operand width in bits.
REQ-002 Parameter TMO, default 1023: maximum cycles spent waiting for the arithmetic core's done (minimum 1).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset: asynchronous, active-low.
REQ-005 i_start  input  1  one-cycle start pulse from the debounced start button.
REQ-006 i_valid  input  1  one-cycle strobe; i_data/i_op from the switch stage are valid in this cycle.
REQ-007 i_data  input  DW  operand value from the switch stage.
REQ-008 i_op  input  2  opcode from the switch stage: 00 none, 01 mul, 10 div, 11 sqrt.
REQ-009 i_done  input  1  one-cycle completion pulse from the arithmetic core.
REQ-010 i_result  input  2*DW  core result (product, quotient in [DW-1:0], or root in [DW-1:0]).
REQ-011 i_rem  input  DW  core remainder (div only).
REQ-012 o_x, o_y  output  DW each  latched operands driven to the core.
REQ-013 o_op  output  2  latched opcode driven to the core.
REQ-014 o_core_start  output  1  one-cycle start pulse to the core.
REQ-015 o_result  output  2*DW  captured result; o_rem  output  DW  captured remainder.
REQ-016 o_ready  output  1  high in IDLE only.
REQ-017 o_wait_x, o_wait_y  output  1 each  high in WAIT_X / WAIT_Y respectively.
REQ-018 o_busy  output  1  high in START and BUSY.
REQ-019 o_valid  output  1  high in DONE; o_error  output  1  high in ERR.

Function
REQ-020 The FSM SHALL have states IDLE, WAIT_X, WAIT_Y, START, BUSY, DONE and ERR, with Moore status outputs decoded from the registered state.
REQ-021 IDLE: i_start SHALL transition to WAIT_X; i_valid and i_done SHALL be ignored.
REQ-022 WAIT_X on i_valid: o_x<=i_data and o_op<=i_op; then go to ERR if i_op=00, START if i_op=11, else WAIT_Y.
REQ-023 WAIT_Y on i_valid: o_y<=i_data, i_op ignored; then go to ERR if o_op=10 and i_data=0, else START.
REQ-024 For sqrt, o_y SHALL be cleared to 0 on the WAIT_X->START transition.
REQ-025 START: o_core_start=1 for exactly one cycle, unconditional transition to BUSY, timeout counter cleared to 0.
REQ-026 BUSY, each cycle: i_done=1 captures o_result<=i_result and o_rem<=(o_op=10 ? i_rem : 0) and goes to DONE; else if counter=TMO go to ERR; else counter+1.
REQ-027 The timeout counter SHALL be clog2(TMO+1) bits wide and SHALL never wrap.
REQ-028 i_done=1 in the same cycle the counter reaches TMO SHALL take priority, going to DONE, not ERR.
REQ-029 DONE and ERR SHALL hold their outputs until i_start, then go to WAIT_X.
REQ-030 On leaving ERR or DONE via i_start: o_x, o_y, o_op, o_result and o_rem SHALL be cleared to 0 in the same edge.
REQ-031 In WAIT_X and WAIT_Y, i_start SHALL restart the sequence (go to WAIT_X, operands cleared); if i_valid is also high, i_start SHALL win.
REQ-032 i_start and i_valid SHALL be ignored in START and BUSY.
REQ-033 o_core_start SHALL never assert outside START.
REQ-034 Operands and results SHALL be unsigned; no width truncation inside the block.

Reset
REQ-035 While rst=0: state=IDLE, counter=0, and all data outputs 0.
REQ-036 While rst=0: o_ready=1 and every other status output and o_core_start = 0.
REQ-037 Reset asserted mid-operation (any state) SHALL abort immediately with no o_core_start pulse; a later i_done SHALL be ignored in IDLE.

Verification
REQ-038 Mul: i_start; i_valid data=0x0012 op=01; i_valid data=0x0003; i_done result=0x36 -> one o_core_start, o_x=0x12, o_y=3, o_valid=1, o_result=0x36.
REQ-039 Div by zero: i_start; op=10 X=0x64; Y=0 -> o_error=1, no o_core_start pulse, state held until i_start -> o_wait_x=1 with operands 0.
REQ-040 Sqrt: i_start; i_valid data=0x0051 op=11 -> START directly (o_wait_y never high), o_y=0; i_done result=9 -> o_result=9, o_rem=0.
REQ-041 Timeout: TMO=4, mul started, no i_done -> o_error asserted 5 cycles after BUSY entry; repeat with i_done on the cycle counter=4 -> o_valid=1.
REQ-042 Op none: i_start; i_valid op=00 -> ERR; also i_start and i_valid together in WAIT_Y -> WAIT_X with operands cleared.
REQ-043 Reset in BUSY: rst low for 1 cycle -> o_ready=1 and outputs 0 immediately; a subsequent i_done pulse causes no state change.
